// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, stall codes and FSM state type for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int STALL_WD    = 6;
    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM read port
// and turns decode-stage branches into fetch redirects after the delay slot.
// A branch seen while fetch is stalled is parked in the redirect latch and
// steers the first fetch after the stall releases.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   redirect_pending
);

    fetch_state_t state;
    logic [31:0]  pc_reg;
    logic         ce_reg;
    logic         redir_v;
    logic [31:0]  redir_pc;
    logic         br_dly_v;
    logic [31:0]  br_dly_pc;
    logic [31:0]  next_pc;
    logic         stall_if;
    logic         br_e;
    logic [31:0]  br_addr;
    logic         unused_stall;

    assign stall_if     = stall[0];
    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign unused_stall = ^stall[STALL_WD-1:1];

    // Fetch address: a parked redirect wins, then a branch whose delay slot
    // has just been fetched, otherwise sequential (wraps naturally at 2^32).
    always_comb begin
        next_pc = pc_reg + PC_STEP;
        if (redir_v) begin
            next_pc = redir_pc;
        end else if (br_dly_v) begin
            next_pc = br_dly_pc;
        end
    end

    // Fetch FSM: pc_reg and ce_reg only move on unstalled edges, so the
    // address seen by decode always matches the SRAM output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= BOOT;
            pc_reg <= RESET_PC - PC_STEP;
            ce_reg <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (stall_if == NO_STOP) begin
                        state  <= RUN;
                        pc_reg <= next_pc;
                        ce_reg <= 1'b1;
                    end
                end
                RUN, HOLD: begin
                    if (stall_if == NO_STOP) begin
                        state  <= RUN;
                        pc_reg <= next_pc;
                    end else begin
                        state  <= HOLD;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    // Branch bookkeeping: stalled branches park in the redirect latch (newest
    // wins); an unstalled branch waits one cycle so its delay slot is fetched
    // first. On the edge that consumes the latch, a fresh branch lands in the
    // delay register rather than re-arming the latch, so it is applied once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redir_v   <= 1'b0;
            redir_pc  <= 32'h0;
            br_dly_v  <= 1'b0;
            br_dly_pc <= 32'h0;
        end else if (stall_if == STOP) begin
            if (br_e) begin
                redir_v  <= 1'b1;
                redir_pc <= br_addr;
            end
        end else begin
            redir_v   <= 1'b0;
            br_dly_v  <= br_e;
            br_dly_pc <= br_addr;
        end
    end

    // The read port idles whenever fetch is stalled or in reset, so the SRAM
    // output register keeps presenting the instruction decode is holding.
    assign inst_sram_en     = resetn & (stall_if == NO_STOP);
    assign inst_sram_wen    = 4'b0000;
    assign inst_sram_wdata  = 32'h0;
    assign inst_sram_addr   = next_pc;
    assign if_to_id_bus     = {ce_reg, pc_reg};
    assign redirect_pending = redir_v;

endmodule
